// File: rtl/demux_stream.sv
// Registered 1-to-N stream demultiplexer with per-channel one-deep output registers.
// The target channel comes from sel (addressed mode) or an internal round-robin pointer (scan mode).
module demux_stream #(
  parameter int WIDTH = 8,
  parameter int N_OUT = 8,
  parameter int SEL_W = $clog2(N_OUT)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   mode,
  output logic [N_OUT*WIDTH-1:0] out_data,
  output logic [N_OUT-1:0]       out_valid,
  input  logic [N_OUT-1:0]       out_ready,
  output logic [SEL_W-1:0]       rr_ptr,
  output logic                   sel_err
);

  localparam logic [SEL_W:0]   N_OUT_W = (SEL_W+1)'(N_OUT);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_OUT - 1);

  logic [N_OUT-1:0][WIDTH-1:0] data_q, data_d;
  logic [N_OUT-1:0]            valid_q, valid_d;
  logic [N_OUT-1:0]            load;
  logic [SEL_W-1:0]            rr_q, rr_d;
  logic                        sel_err_q, sel_err_d;
  logic [SEL_W-1:0]            tgt;
  logic                        tgt_ok;
  logic                        accept;

  assign tgt    = mode ? rr_q : sel;
  assign tgt_ok = {1'b0, tgt} < N_OUT_W;

  // Out-of-range targets are always ready so the offending word is swallowed, not stalled.
  assign in_ready = tgt_ok ? (!valid_q[tgt] || out_ready[tgt]) : 1'b1;
  assign accept   = in_valid && in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_load
      assign load[gi] = accept && tgt_ok && (tgt == SEL_W'(gi));
    end
  endgenerate

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    for (int k = 0; k < N_OUT; k++) begin
      if (load[k]) begin
        data_d[k]  = in_data;
        valid_d[k] = 1'b1;
      end else if (out_ready[k]) begin
        valid_d[k] = 1'b0;
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (accept && mode) begin
      rr_d = (rr_q == LAST_CH) ? '0 : rr_q + 1'b1;
    end
  end

  assign sel_err_d = accept && !tgt_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q    <= '0;
      valid_q   <= '0;
      rr_q      <= '0;
      sel_err_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      rr_q      <= rr_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign rr_ptr    = rr_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_demux_stream.sv
// Bench for demux_stream: directed vector table on an 8-channel instance, hand sequences
// on a 5-channel instance, and randomized traffic against a channel-level reference model.
`timescale 1ns/1ps
module tb_demux_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic        rst_n, in_valid, mode, in_ready, sel_err;
  logic [7:0]  in_data, out_valid, out_ready;
  logic [2:0]  sel, rr_ptr;
  logic [63:0] out_data;

  demux_stream #(.WIDTH(8), .N_OUT(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .mode(mode), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .rr_ptr(rr_ptr), .sel_err(sel_err)
  );

  logic        r5_n, v5, mode5, rdy5, err5;
  logic [7:0]  d5;
  logic [2:0]  sel5, ptr5;
  logic [4:0]  ov5, ordy5;
  logic [39:0] od5;

  demux_stream #(.WIDTH(8), .N_OUT(5)) u_dut5 (
    .clk(clk), .rst_n(r5_n), .in_data(d5), .in_valid(v5), .in_ready(rdy5),
    .sel(sel5), .mode(mode5), .out_data(od5), .out_valid(ov5),
    .out_ready(ordy5), .rr_ptr(ptr5), .sel_err(err5)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst_n;
    logic       iv;
    logic       md;
    logic [2:0] sel;
    logic [7:0] data;
    logic [7:0] ordy;
    logic       exp_rdy;
    logic [7:0] exp_valid;
    logic [2:0] exp_ptr;
    int         chk_ch;
    logic [7:0] exp_d;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input int r, input int iv, input int md, input int s, input int d,
                              input int ordy, input int rdy, input int ev, input int ep,
                              input int ch, input int ed);
    vec_t v;
    v.rst_n = 1'(r);     v.iv = 1'(iv);      v.md = 1'(md);       v.sel = 3'(s);
    v.data = 8'(d);      v.ordy = 8'(ordy);  v.exp_rdy = 1'(rdy); v.exp_valid = 8'(ev);
    v.exp_ptr = 3'(ep);  v.chk_ch = ch;      v.exp_d = 8'(ed);
    tbl.push_back(v);
  endfunction

  // Reference model state for the 8-channel instance
  logic [7:0]  mv;
  logic [7:0]  md [8];
  int          mp;
  logic [63:0] exp_flat;
  int          tgt, ch;
  logic        exp_rdy, acc;

  initial begin
    // Reset mid-traffic: fill ch2/ch5, reset, then idle
    add(1,1,0,2,'h11,'h00, 1,'h04,0, 2,'h11);
    add(1,1,0,5,'h22,'h00, 1,'h24,0, 5,'h22);
    add(0,0,0,2,'h00,'h00, 0,'h00,0, 2,'h00);
    add(1,0,0,2,'h00,'h00, 1,'h00,0, 5,'h00);
    // Addressed backpressure on channel 3
    add(1,1,0,3,'hA5,'h00, 1,'h08,0, 3,'hA5);
    add(1,1,0,3,'h5A,'h00, 0,'h08,0, 3,'hA5);
    add(1,1,0,3,'h5A,'h08, 1,'h08,0, 3,'h5A);
    add(1,0,0,3,'h00,'hFF, 1,'h00,0, 3,'h5A);
    // Scan mode, 10 words back-to-back with wrap
    for (int i = 0; i < 10; i++)
      add(1,1,1,0,i,'hFF, 1,1<<(i%8),(i+1)%8, i%8,i);
    // Scan stall at pointer 4 with channel 4 full
    add(1,1,0,4,'h44,'h00, 1,'h12,2, 4,'h44);
    add(1,1,1,0,'h52,'hEF, 1,'h14,3, 2,'h52);
    add(1,1,1,0,'h53,'hEF, 1,'h18,4, 3,'h53);
    add(1,1,1,0,'h54,'hEF, 0,'h10,4, 4,'h44);
    add(1,1,1,0,'h54,'hEF, 0,'h10,4, 4,'h44);
    add(1,1,1,0,'h54,'hFF, 1,'h10,5, 4,'h54);
    // Walk pointer to 2, then mode switch
    for (int i = 0; i < 5; i++) begin
      ch = (5 + i) % 8;
      add(1,1,1,0,'h60+i,'hFF, 1,1<<ch,(ch+1)%8, ch,'h60+i);
    end
    add(1,1,0,6,'h66,'hFF, 1,'h40,2, 6,'h66);
    add(1,1,1,6,'h70,'hFF, 1,'h04,3, 2,'h70);

    rst_n = 1'b0; in_valid = 1'b0; mode = 1'b0; sel = '0; in_data = '0; out_ready = '0;
    r5_n = 1'b0; v5 = 1'b0; mode5 = 1'b0; sel5 = '0; d5 = '0; ordy5 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    foreach (tbl[i]) begin
      rst_n = tbl[i].rst_n; in_valid = tbl[i].iv; mode = tbl[i].md;
      sel = tbl[i].sel; in_data = tbl[i].data; out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'(tbl[i].exp_rdy));
      @(posedge clk); #1;
      chk($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(tbl[i].exp_valid));
      chk($sformatf("vec%0d rr_ptr", i), 64'(rr_ptr), 64'(tbl[i].exp_ptr));
      chk($sformatf("vec%0d data_ch%0d", i, tbl[i].chk_ch),
          64'(out_data[tbl[i].chk_ch*8 +: 8]), 64'(tbl[i].exp_d));
      chk($sformatf("vec%0d sel_err", i), 64'(sel_err), 64'd0);
      $display("vec %0d: mode=%0d sel=%0d data=%02h valid=%02h ptr=%0d", i, mode, sel, in_data,
               out_valid, rr_ptr);
      @(negedge clk);
    end
    // Reset-mid-traffic leaves every channel cleared (checked again as a whole)
    rst_n = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("reset out_data", out_data, 64'd0);
    chk("reset in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Five-channel instance: out-of-range drop and non-power-of-two wrap
    r5_n = 1'b1; mode5 = 1'b0; sel5 = 3'd1; d5 = 8'h12; v5 = 1'b1; ordy5 = '0;
    #1; chk("n5 load in_ready", 64'(rdy5), 64'd1);
    @(posedge clk); #1;
    chk("n5 load valid", 64'(ov5), 64'h02);
    chk("n5 load data", 64'(od5), 64'h0000001200);
    $display("n5 load: sel=1 data=12 valid=%05b", ov5);
    @(negedge clk);
    for (int s = 5; s <= 6; s++) begin
      sel5 = 3'(s); d5 = 8'h77; v5 = 1'b1;
      #1; chk($sformatf("n5 sel%0d in_ready", s), 64'(rdy5), 64'd1);
      @(posedge clk); #1;
      chk($sformatf("n5 sel%0d valid", s), 64'(ov5), 64'h02);
      chk($sformatf("n5 sel%0d data", s), 64'(od5), 64'h0000001200);
      chk($sformatf("n5 sel%0d sel_err", s), 64'(err5), 64'd1);
      $display("n5 drop: sel=%0d sel_err=%0d valid=%05b", s, err5, ov5);
      @(negedge clk);
      v5 = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("n5 sel%0d sel_err end", s), 64'(err5), 64'd0);
      chk($sformatf("n5 sel%0d valid after", s), 64'(ov5), 64'h02);
      @(negedge clk);
    end
    mode5 = 1'b1; ordy5 = 5'h1F; v5 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d5 = 8'(8'h80 + i);
      #1; chk($sformatf("n5 scan%0d in_ready", i), 64'(rdy5), 64'd1);
      @(posedge clk); #1;
      chk($sformatf("n5 scan%0d rr_ptr", i), 64'(ptr5), 64'((i + 1) % 5));
      chk($sformatf("n5 scan%0d valid", i), 64'(ov5), 64'(1 << (i % 5)));
      chk($sformatf("n5 scan%0d data", i), 64'(od5[(i%5)*8 +: 8]), 64'(8'h80 + i));
      $display("n5 scan %0d: ptr=%0d valid=%05b", i, ptr5, ov5);
      @(negedge clk);
    end
    v5 = 1'b0;

    // Randomized traffic on the 8-channel instance against the reference model
    rst_n = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    mv = '0; mp = 0;
    for (int k = 0; k < 8; k++) md[k] = '0;
    for (int n = 0; n < 400; n++) begin
      rst_n     = ($urandom_range(0, 39) != 0);
      in_valid  = 1'($urandom);
      mode      = 1'($urandom);
      sel       = 3'($urandom);
      in_data   = 8'($urandom);
      out_ready = 8'($urandom) | 8'($urandom);
      tgt     = mode ? mp : int'(sel);
      exp_rdy = !mv[tgt] || out_ready[tgt];
      acc     = in_valid && exp_rdy;
      #1; chk($sformatf("rnd%0d in_ready", n), 64'(in_ready), 64'(exp_rdy));
      @(posedge clk);
      if (!rst_n) begin
        mv = '0; mp = 0;
        for (int k = 0; k < 8; k++) md[k] = '0;
      end else begin
        for (int k = 0; k < 8; k++) begin
          if (acc && k == tgt) begin
            mv[k] = 1'b1; md[k] = in_data;
          end else if (out_ready[k]) begin
            mv[k] = 1'b0;
          end
        end
        if (acc && mode) mp = (mp + 1) % 8;
      end
      for (int k = 0; k < 8; k++) exp_flat[k*8 +: 8] = md[k];
      #1;
      chk($sformatf("rnd%0d out_valid", n), 64'(out_valid), 64'(mv));
      chk($sformatf("rnd%0d out_data", n), out_data, exp_flat);
      chk($sformatf("rnd%0d rr_ptr", n), 64'(rr_ptr), 64'(mp));
      chk($sformatf("rnd%0d sel_err", n), 64'(sel_err), 64'd0);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
